// File: rtl/seq_mem_rf_2r1w_param_pkg.sv
// Package: seq_mem_rf_pkg
//
// Shared types for the 2-read/1-write register file slice.
// - rf_clear_state_t : state encoding of the bulk-clear sequencer.
package seq_mem_rf_pkg;

  typedef enum logic {
    RF_IDLE  = 1'b0,
    RF_CLEAR = 1'b1
  } rf_clear_state_t;

endpackage

// File: rtl/seq_mem_rf_2r1w_param_if.sv
// Interface: seq_mem_rf_2r1w_param_if
//
// Groups the read, write and clear signals of the register file.
// - slave  : register-file side (addresses/requests in, data/status out)
// - master : requester side (addresses/requests out, data/status in)
// Parameters: AW address width, DW data width.
interface seq_mem_rf_2r1w_param_if #(
  parameter int AW = 3,
  parameter int DW = 8
);

  logic [AW-1:0] read_addr0;
  logic [DW-1:0] read_data0;
  logic [AW-1:0] read_addr1;
  logic [DW-1:0] read_data1;
  logic          write_en;
  logic [AW-1:0] write_addr;
  logic [DW-1:0] write_data;
  logic          write_rdy;
  logic          clear_req;
  logic          clear_busy;

  modport slave (
    input  read_addr0, read_addr1, write_en, write_addr, write_data, clear_req,
    output read_data0, read_data1, write_rdy, clear_busy
  );

  modport master (
    output read_addr0, read_addr1, write_en, write_addr, write_data, clear_req,
    input  read_data0, read_data1, write_rdy, clear_busy
  );

endinterface

// File: rtl/seq_mem_rf_2r1w_param_clear_fsm.sv
// Module: seq_mem_rf_clear_fsm
//
// Bulk-clear sequencer: on clear_req in IDLE it walks every entry index,
// one per cycle, for exactly NUM_REGS cycles, then returns to IDLE.
// Ports:
// - clk, reset_n  : clock, asynchronous active-low reset
// - clear_req     : request pulse (ignored while a clear is running)
// - clear_busy    : 1 while the sequence runs
// - clear_we      : write strobe for the storage array (zero write)
// - clear_idx     : entry being zeroed this cycle
module seq_mem_rf_clear_fsm
  import seq_mem_rf_pkg::*;
#(
  parameter  int NUM_REGS = 8,
  localparam int AW       = $clog2(NUM_REGS)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          clear_req,
  output logic          clear_busy,
  output logic          clear_we,
  output logic [AW-1:0] clear_idx
);

  localparam logic [AW-1:0] LAST_IDX = AW'(NUM_REGS - 1);
  localparam logic [AW-1:0] IDX_ONE  = {{(AW-1){1'b0}}, 1'b1};

  rf_clear_state_t state_r;
  logic [AW-1:0]   idx_r;

  // Sequencer state and index; the last index exits before the index could wrap
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= RF_IDLE;
      idx_r   <= '0;
    end else begin
      case (state_r)
        RF_IDLE: begin
          if (clear_req) begin
            state_r <= RF_CLEAR;
          end else begin
            state_r <= RF_IDLE;
          end
          idx_r <= '0;
        end
        RF_CLEAR: begin
          if (idx_r == LAST_IDX) begin
            state_r <= RF_IDLE;
            idx_r   <= '0;
          end else begin
            idx_r <= idx_r + IDX_ONE;
          end
        end
        default: begin
          state_r <= RF_IDLE;
          idx_r   <= '0;
        end
      endcase
    end
  end

  // Outputs decode straight from the state/index registers
  assign clear_busy = (state_r == RF_CLEAR);
  assign clear_we   = (state_r == RF_CLEAR);
  assign clear_idx  = idx_r;

endmodule

// File: rtl/seq_mem_rf_2r1w_param.sv
// Module: seq_mem_rf_2r1w_param
//
// Parametrised register file: two combinational read ports, one synchronous
// write port, optional hardwired-zero entry 0, optional write-to-read bypass
// and a sequenced bulk clear that stalls writes via write_rdy.
// Ports:
// - clk, reset_n : clock, asynchronous active-low reset
// - rf (slave)   : read_addr0/1 -> read_data0/1, write_en/addr/data,
//                  write_rdy, clear_req, clear_busy
module seq_mem_rf_2r1w_param
  import seq_mem_rf_pkg::*;
#(
  parameter int NUM_REGS   = 8,
  parameter int DATA_WIDTH = 8,
  parameter int ZERO_REG   = 1,
  parameter int BYPASS_EN  = 1
) (
  input  logic                     clk,
  input  logic                     reset_n,
  seq_mem_rf_2r1w_param_if.slave   rf
);

  localparam int AW = $clog2(NUM_REGS);

  logic [DATA_WIDTH-1:0] mem_r [NUM_REGS];
  logic                  clear_busy_s;
  logic                  clear_we_s;
  logic [AW-1:0]         clear_idx_s;
  logic                  wr_fire_s;
  logic                  wr_commit_s;
  logic [DATA_WIDTH-1:0] rd0_s;
  logic [DATA_WIDTH-1:0] rd1_s;

  // Read priority: hardwired zero, then same-cycle bypass, then stored value
  function automatic logic [DATA_WIDTH-1:0] rd_sel(
    input logic [AW-1:0]         addr,
    input logic [DATA_WIDTH-1:0] stored,
    input logic                  fire,
    input logic [AW-1:0]         waddr,
    input logic [DATA_WIDTH-1:0] wdata
  );
    logic [DATA_WIDTH-1:0] res;
    if ((ZERO_REG != 0) && (addr == '0)) begin
      res = '0;
    end else if ((BYPASS_EN != 0) && fire && (waddr == addr)) begin
      res = wdata;
    end else begin
      res = stored;
    end
    return res;
  endfunction

  seq_mem_rf_clear_fsm #(
    .NUM_REGS (NUM_REGS)
  ) u_clear_fsm (
    .clk        (clk),
    .reset_n    (reset_n),
    .clear_req  (rf.clear_req),
    .clear_busy (clear_busy_s),
    .clear_we   (clear_we_s),
    .clear_idx  (clear_idx_s)
  );

  assign wr_fire_s   = rf.write_en & ~clear_busy_s;
  // Writes to the hardwired-zero entry are accepted but never stored
  assign wr_commit_s = wr_fire_s & ~((ZERO_REG != 0) && (rf.write_addr == '0));

  // Storage array; the clear strobe takes precedence over a user write
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        mem_r[i] <= '0;
      end
    end else if (clear_we_s) begin
      mem_r[clear_idx_s] <= '0;
    end else if (wr_commit_s) begin
      mem_r[rf.write_addr] <= rf.write_data;
    end
  end

  // Both read ports, fully independent of each other
  always_comb begin
    rd0_s = rd_sel(rf.read_addr0, mem_r[rf.read_addr0], wr_fire_s,
                   rf.write_addr, rf.write_data);
    rd1_s = rd_sel(rf.read_addr1, mem_r[rf.read_addr1], wr_fire_s,
                   rf.write_addr, rf.write_data);
  end

  assign rf.read_data0 = rd0_s;
  assign rf.read_data1 = rd1_s;
  assign rf.write_rdy  = ~clear_busy_s;
  assign rf.clear_busy = clear_busy_s;

endmodule
